mem_bridge: RTL and testbench
=============================

Name: mem_bridge

Overview:
- Downstream stage of the CNN accelerator's memory port: converts the accelerator's single-cycle RE/WE/ADDR/DATA requests into Avalon-MM master transactions on m0, honouring AVS_m0_waitrequest.
- Scales word addresses to byte addresses, sign-extends 16-bit write data to 32 bits, and returns 16-bit read data with a one-cycle valid strobe.
- Applies back-pressure to the accelerator through a ready signal.
- Holds one outstanding transaction, with a waitrequest watchdog and a sticky error flag.

Parameters:
- DATA_WIDTH, 16, accelerator-side data width; must be ≤ 32.
- ADDR_WIDTH, 32, accelerator word-address width and Avalon address width.
- BASE_ADDR, 32'h0, byte offset added to every scaled address.
- TIMEOUT_CYCLES, 1024, maximum consecutive waitrequest cycles before a transaction is aborted; 0 disables the watchdog.

Ports:
- MEM_BRIDGE_Clk  in  1  sole clock
- MEM_BRIDGE_Reset  in  1  synchronous, active-high reset
- MEM_BRIDGE_Req_Re  in  1  accelerator read request
- MEM_BRIDGE_Req_We  in  1  accelerator write request
- MEM_BRIDGE_Req_Addr  in  ADDR_WIDTH  word address
- MEM_BRIDGE_Req_Wdata  in  DATA_WIDTH  write data, signed
- MEM_BRIDGE_Req_Ready  out  1  bridge can accept a request this cycle
- MEM_BRIDGE_Rsp_Valid  out  1  one-cycle pulse, read data valid
- MEM_BRIDGE_Rsp_Data  out  DATA_WIDTH  read data
- MEM_BRIDGE_Err  out  1  sticky timeout/collision error
- MEM_BRIDGE_Err_Clr  in  1  clears MEM_BRIDGE_Err
- MEM_BRIDGE_M_Address  out  32  Avalon byte address
- MEM_BRIDGE_M_Read  out  1  Avalon read
- MEM_BRIDGE_M_Write  out  1  Avalon write
- MEM_BRIDGE_M_Writedata  out  32  Avalon write data
- MEM_BRIDGE_M_Byteenable  out  4  constant 4'b1111
- MEM_BRIDGE_M_Readdata  in  32  Avalon read data
- MEM_BRIDGE_M_Waitrequest  in  1  Avalon wait request

Behaviour:
- One clock domain, MEM_BRIDGE_Clk. MEM_BRIDGE_Reset is synchronous and active-high.
- Reset values: state IDLE; M_Read=0, M_Write=0, M_Address=0, M_Writedata=0, Rsp_Valid=0, Rsp_Data=0, Err=0, watchdog=0. Req_Ready=1 in the first cycle after reset.
- FSM states: IDLE, RD, WR.
- Req_Ready = (state==IDLE), combinational.
- IDLE: a request is accepted in any cycle with Req_Ready=1 and (Re|We); address and data are registered on that cycle.
  - We only: go to WR.
  - Re only: go to RD.
  - Re and We together: write wins, go to WR, set Err.
- Address: M_Address = BASE_ADDR + (Req_Addr << 2), modulo 2^32; upper bits that overflow are dropped.
- Write data: M_Writedata = sign-extension of Req_Wdata to 32 bits.
- M_Read/M_Write are registered and assert in the cycle after acceptance (t+1). They are held, with address and data stable, while Waitrequest=1.
- RD: in the first cycle with Waitrequest=0:
  - capture Readdata[DATA_WIDTH-1:0] into Rsp_Data;
  - pulse Rsp_Valid on the next cycle (t+2 for a zero-wait slave);
  - drop M_Read and return to IDLE.
  - Rsp_Data holds its value until the next read completes.
- WR: in the first cycle with Waitrequest=0, drop M_Write and return to IDLE. No response pulse is generated.
- Minimum throughput: one transaction every 2 cycles. Req_Ready returns to 1 in the cycle after completion.
- Requests presented while Req_Ready=0 are ignored. The accelerator must hold them until it sees Req_Ready.
- Watchdog: counts consecutive Waitrequest=1 cycles in RD/WR and resets on completion. When the count reaches TIMEOUT_CYCLES:
  - deassert M_Read/M_Write, set Err, return to IDLE;
  - on an aborted read, pulse Rsp_Valid with Rsp_Data=0 so the accelerator never deadlocks.
- Err clears on Err_Clr=1. If a set event and Err_Clr occur in the same cycle, set wins.
- Reset mid-transaction: at the reset edge, return to IDLE and drop M_Read/M_Write regardless of Waitrequest.

Optional Feature:
- Macro: MEM_BRIDGE_PERF_CNT_EN.
- When defined, add 32-bit output ports MEM_BRIDGE_Rd_Count, MEM_BRIDGE_Wr_Count and MEM_BRIDGE_Stall_Count.
  - Rd_Count/Wr_Count increment on each completed (non-aborted) read or write.
  - Stall_Count increments on every RD/WR cycle with Waitrequest=1.
  - All three wrap at 2^32, are cleared by reset, and are also cleared by Err_Clr.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Zero-wait read: Req_Re=1, Addr=5, slave Readdata=32'h0000_8001 → M_Read at t+1 with M_Address=0x14; Rsp_Valid at t+2 with Rsp_Data=16'h8001; Req_Ready low for exactly t+1.
- Write with 3 wait cycles: Req_We=1, Addr=3, Wdata=16'hFFFE, Waitrequest=1 for 3 cycles → M_Write held 4 cycles; M_Address=0x0C; M_Writedata=32'hFFFF_FFFE; Byteenable=4'hF; no Rsp_Valid.
- Collision: Re=1 and We=1 in the same cycle → WR transaction only, Err=1; Err_Clr pulse → Err=0.
- Timeout: TIMEOUT_CYCLES=8, read with Waitrequest stuck high → M_Read drops after 8 stall cycles; Rsp_Valid pulses with Rsp_Data=0; Err=1; Req_Ready=1 on the next cycle.
- Reset mid-read: assert Reset while in RD with Waitrequest=1 → next edge M_Read=0, Req_Ready=1, Rsp_Valid never pulses.
- Address wrap and back-to-back traffic: BASE_ADDR=32'hFFFF_FFF0, Addr=8 → M_Address=0x10; 10 consecutive zero-wait reads complete in 20 cycles; with MEM_BRIDGE_PERF_CNT_EN defined, Rd_Count=10.

Source files
------------

// File: rtl/mem_bridge.sv
// Accelerator-to-Avalon-MM master bridge: one outstanding transaction, waitrequest watchdog, sticky error.
// Optional performance counters are built when MEM_BRIDGE_PERF_CNT_EN is defined.
module mem_bridge #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  MEM_BRIDGE_Clk,
  input  logic                  MEM_BRIDGE_Reset,
  input  logic                  MEM_BRIDGE_Req_Re,
  input  logic                  MEM_BRIDGE_Req_We,
  input  logic [ADDR_WIDTH-1:0] MEM_BRIDGE_Req_Addr,
  input  logic [DATA_WIDTH-1:0] MEM_BRIDGE_Req_Wdata,
  output logic                  MEM_BRIDGE_Req_Ready,
  output logic                  MEM_BRIDGE_Rsp_Valid,
  output logic [DATA_WIDTH-1:0] MEM_BRIDGE_Rsp_Data,
  output logic                  MEM_BRIDGE_Err,
  input  logic                  MEM_BRIDGE_Err_Clr,
  output logic [31:0]           MEM_BRIDGE_M_Address,
  output logic                  MEM_BRIDGE_M_Read,
  output logic                  MEM_BRIDGE_M_Write,
  output logic [31:0]           MEM_BRIDGE_M_Writedata,
  output logic [3:0]            MEM_BRIDGE_M_Byteenable,
  input  logic [31:0]           MEM_BRIDGE_M_Readdata,
  input  logic                  MEM_BRIDGE_M_Waitrequest
`ifdef MEM_BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0]           MEM_BRIDGE_Rd_Count,
  output logic [31:0]           MEM_BRIDGE_Wr_Count,
  output logic [31:0]           MEM_BRIDGE_Stall_Count
`endif
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state;
  logic [31:0] wd_cnt;
  logic [31:0] addr_word;
  logic [31:0] byte_addr;
  logic        accept;
  logic        busy;
  logic        done;
  logic        wd_expire;
  logic        err_set;
  logic        unused_rdata;

  assign MEM_BRIDGE_Req_Ready    = (state == IDLE);
  assign MEM_BRIDGE_M_Byteenable = 4'hF;

  assign accept    = MEM_BRIDGE_Req_Ready & (MEM_BRIDGE_Req_Re | MEM_BRIDGE_Req_We);
  assign busy      = (state != IDLE);
  assign done      = busy & ~MEM_BRIDGE_M_Waitrequest;
  // Abort on the TIMEOUT_CYCLES-th consecutive stall cycle; a zero timeout never fires.
  assign wd_expire = busy & MEM_BRIDGE_M_Waitrequest & (TIMEOUT_CYCLES != 0)
                     & (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign err_set   = (accept & MEM_BRIDGE_Req_Re & MEM_BRIDGE_Req_We) | wd_expire;

  assign addr_word = 32'(MEM_BRIDGE_Req_Addr);
  assign byte_addr = BASE_ADDR + (addr_word << 2);

  assign unused_rdata = ^(MEM_BRIDGE_M_Readdata >> DATA_WIDTH);

  always_ff @(posedge MEM_BRIDGE_Clk) begin
    if (MEM_BRIDGE_Reset) begin
      state                  <= IDLE;
      wd_cnt                 <= '0;
      MEM_BRIDGE_M_Read      <= 1'b0;
      MEM_BRIDGE_M_Write     <= 1'b0;
      MEM_BRIDGE_M_Address   <= '0;
      MEM_BRIDGE_M_Writedata <= '0;
      MEM_BRIDGE_Rsp_Valid   <= 1'b0;
      MEM_BRIDGE_Rsp_Data    <= '0;
    end else begin
      MEM_BRIDGE_Rsp_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            MEM_BRIDGE_M_Address   <= byte_addr;
            MEM_BRIDGE_M_Writedata <= 32'($signed(MEM_BRIDGE_Req_Wdata));
            wd_cnt                 <= '0;
            if (MEM_BRIDGE_Req_We) begin
              state              <= WR;
              MEM_BRIDGE_M_Write <= 1'b1;
            end else begin
              state             <= RD;
              MEM_BRIDGE_M_Read <= 1'b1;
            end
          end
        end
        RD, WR: begin
          if (done || wd_expire) begin
            state              <= IDLE;
            wd_cnt             <= '0;
            MEM_BRIDGE_M_Read  <= 1'b0;
            MEM_BRIDGE_M_Write <= 1'b0;
            // An aborted read still answers (with zero) so the accelerator cannot deadlock.
            if (state == RD) begin
              MEM_BRIDGE_Rsp_Valid <= 1'b1;
              MEM_BRIDGE_Rsp_Data  <= done ? MEM_BRIDGE_M_Readdata[DATA_WIDTH-1:0] : '0;
            end
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        default: begin
          state              <= IDLE;
          MEM_BRIDGE_M_Read  <= 1'b0;
          MEM_BRIDGE_M_Write <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge MEM_BRIDGE_Clk) begin
    if (MEM_BRIDGE_Reset)
      MEM_BRIDGE_Err <= 1'b0;
    else if (err_set)
      MEM_BRIDGE_Err <= 1'b1;
    else if (MEM_BRIDGE_Err_Clr)
      MEM_BRIDGE_Err <= 1'b0;
  end

`ifdef MEM_BRIDGE_PERF_CNT_EN
  always_ff @(posedge MEM_BRIDGE_Clk) begin
    if (MEM_BRIDGE_Reset || MEM_BRIDGE_Err_Clr) begin
      MEM_BRIDGE_Rd_Count    <= '0;
      MEM_BRIDGE_Wr_Count    <= '0;
      MEM_BRIDGE_Stall_Count <= '0;
    end else begin
      if (done && state == RD)
        MEM_BRIDGE_Rd_Count <= MEM_BRIDGE_Rd_Count + 32'd1;
      if (done && state == WR)
        MEM_BRIDGE_Wr_Count <= MEM_BRIDGE_Wr_Count + 32'd1;
      if (busy && MEM_BRIDGE_M_Waitrequest)
        MEM_BRIDGE_Stall_Count <= MEM_BRIDGE_Stall_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: two instances (base 0 and a wrapping base) driven in lockstep
// and compared against a transaction-level reference model.
module tb_mem_bridge;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFF0;
  localparam int          TMO   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we, err_clr, waitreq;
  logic [31:0] addr, rdata_in;
  logic [15:0] wdata;

  logic        rdy [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data [2];
  logic        err [2];
  logic [31:0] m_addr [2];
  logic        m_read [2];
  logic        m_write [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be [2];
`ifdef MEM_BRIDGE_PERF_CNT_EN
  logic [31:0] rd_cnt [2];
  logic [31:0] wr_cnt [2];
  logic [31:0] stall_cnt [2];
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .BASE_ADDR(BASE0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .MEM_BRIDGE_Clk(clk), .MEM_BRIDGE_Reset(rst),
    .MEM_BRIDGE_Req_Re(re), .MEM_BRIDGE_Req_We(we),
    .MEM_BRIDGE_Req_Addr(addr), .MEM_BRIDGE_Req_Wdata(wdata),
    .MEM_BRIDGE_Req_Ready(rdy[0]), .MEM_BRIDGE_Rsp_Valid(rsp_valid[0]),
    .MEM_BRIDGE_Rsp_Data(rsp_data[0]), .MEM_BRIDGE_Err(err[0]), .MEM_BRIDGE_Err_Clr(err_clr),
    .MEM_BRIDGE_M_Address(m_addr[0]), .MEM_BRIDGE_M_Read(m_read[0]),
    .MEM_BRIDGE_M_Write(m_write[0]), .MEM_BRIDGE_M_Writedata(m_wdata[0]),
    .MEM_BRIDGE_M_Byteenable(m_be[0]), .MEM_BRIDGE_M_Readdata(rdata_in),
    .MEM_BRIDGE_M_Waitrequest(waitreq)
`ifdef MEM_BRIDGE_PERF_CNT_EN
    , .MEM_BRIDGE_Rd_Count(rd_cnt[0]), .MEM_BRIDGE_Wr_Count(wr_cnt[0]),
    .MEM_BRIDGE_Stall_Count(stall_cnt[0])
`endif
  );

  mem_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .BASE_ADDR(BASE1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .MEM_BRIDGE_Clk(clk), .MEM_BRIDGE_Reset(rst),
    .MEM_BRIDGE_Req_Re(re), .MEM_BRIDGE_Req_We(we),
    .MEM_BRIDGE_Req_Addr(addr), .MEM_BRIDGE_Req_Wdata(wdata),
    .MEM_BRIDGE_Req_Ready(rdy[1]), .MEM_BRIDGE_Rsp_Valid(rsp_valid[1]),
    .MEM_BRIDGE_Rsp_Data(rsp_data[1]), .MEM_BRIDGE_Err(err[1]), .MEM_BRIDGE_Err_Clr(err_clr),
    .MEM_BRIDGE_M_Address(m_addr[1]), .MEM_BRIDGE_M_Read(m_read[1]),
    .MEM_BRIDGE_M_Write(m_write[1]), .MEM_BRIDGE_M_Writedata(m_wdata[1]),
    .MEM_BRIDGE_M_Byteenable(m_be[1]), .MEM_BRIDGE_M_Readdata(rdata_in),
    .MEM_BRIDGE_M_Waitrequest(waitreq)
`ifdef MEM_BRIDGE_PERF_CNT_EN
    , .MEM_BRIDGE_Rd_Count(rd_cnt[1]), .MEM_BRIDGE_Wr_Count(wr_cnt[1]),
    .MEM_BRIDGE_Stall_Count(stall_cnt[1])
`endif
  );

  // Reference model state (transaction level)
  logic        model_err;
  logic [15:0] model_rsp;
  int          model_rd, model_wr, model_stall;

  // Observations of the last transaction
  int          obs_cycles;
  bit          obs_rd, obs_wr, obs_unstable, obs_busy_rsp, obs_ready_busy;
  logic [31:0] obs_addr [2];
  logic [31:0] obs_wd;
  logic [3:0]  obs_be;
  logic        obs_rsp_valid;
  logic [15:0] obs_rsp_data [2];
  logic        obs_err [2];
  logic        obs_ready_end;

  function automatic logic [31:0] exp_addr(input int i, input logic [31:0] a);
    logic [31:0] base;
    base = (i == 0) ? BASE0 : BASE1;
    return base + a * 32'd4;
  endfunction

  function automatic logic [31:0] exp_sext(input logic [15:0] d);
    logic [31:0] v;
    v = 32'(d);
    if (d >= 16'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic int exp_cycles(input int waits);
    return (waits >= TMO) ? TMO : waits + 1;
  endfunction

  // Precondition: called right after a negedge in a cycle where the bridge is idle.
  // Returns at the negedge of the first cycle after the bus transaction ends.
  task automatic do_txn(input logic r, input logic w, input logic [31:0] a, input logic [15:0] d,
                        input int waits, input logic [31:0] rd, input logic clr, input bit noise);
    int k;
    re = r; we = w; addr = a; wdata = d; err_clr = clr;
    waitreq = 1'($urandom); rdata_in = $urandom;
    @(negedge clk);
    re = 1'b0; we = 1'b0; err_clr = 1'b0;
    obs_addr[0] = m_addr[0]; obs_addr[1] = m_addr[1];
    obs_wd = m_wdata[0]; obs_be = m_be[0];
    obs_rd = m_read[0]; obs_wr = m_write[0];
    obs_unstable = 0; obs_busy_rsp = 0; obs_ready_busy = 0;
    k = 0;
    while ((m_read[0] | m_write[0] | m_read[1] | m_write[1]) && k < 40) begin
      if (m_addr[0] !== obs_addr[0] || m_addr[1] !== obs_addr[1] || m_wdata[0] !== obs_wd ||
          m_read[0] !== obs_rd || m_write[0] !== obs_wr || m_read[1] !== obs_rd ||
          m_write[1] !== obs_wr)
        obs_unstable = 1;
      if (rsp_valid[0] | rsp_valid[1]) obs_busy_rsp = 1;
      if (rdy[0] | rdy[1]) obs_ready_busy = 1;
      waitreq  = (k < waits);
      rdata_in = (k < waits) ? $urandom : rd;
      if (noise) begin
        re = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = 16'($urandom);
      end
      k++;
      @(negedge clk);
    end
    re = 1'b0; we = 1'b0; waitreq = 1'b0;
    obs_cycles = k;
    obs_rsp_valid = rsp_valid[0] & rsp_valid[1];
    if (rsp_valid[0] !== rsp_valid[1]) obs_rsp_valid = 1'bx;
    obs_rsp_data[0] = rsp_data[0]; obs_rsp_data[1] = rsp_data[1];
    obs_err[0] = err[0]; obs_err[1] = err[1];
    obs_ready_end = rdy[0] & rdy[1];
  endtask

  // Transaction-level model update for one accepted request.
  task automatic model_txn(input logic r, input logic w, input int waits,
                           input logic [31:0] rd, input logic clr);
    bit aborted;
    aborted = (waits >= TMO);
    if (r && w) model_err = 1'b1;
    else if (clr) model_err = 1'b0;
    if (clr) begin model_rd = 0; model_wr = 0; model_stall = 0; end
    if (aborted) model_err = 1'b1;
    model_stall += (waits >= TMO) ? TMO : waits;
    if (!w) begin
      model_rsp = aborted ? 16'h0 : rd[15:0];
      if (!aborted) model_rd++;
    end else if (!aborted) begin
      model_wr++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; re = 0; we = 0; err_clr = 0; waitreq = 0; addr = 0; wdata = 0; rdata_in = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_err = 0; model_rsp = 0; model_rd = 0; model_wr = 0; model_stall = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({rdy[i], m_read[i], m_write[i], rsp_valid[i], err[i]} !== 5'b10000)
        $display("FAIL reset_ctrl dut%0d: got rdy/rd/wr/vld/err=%b%b%b%b%b want 10000",
                 i, rdy[i], m_read[i], m_write[i], rsp_valid[i], err[i]);
      else ;
      if ({rdy[i], m_read[i], m_write[i], rsp_valid[i], err[i]} !== 5'b10000) errors++;
      checks++;
      if (m_addr[i] !== 32'h0 || m_wdata[i] !== 32'h0 || rsp_data[i] !== 16'h0 || m_be[i] !== 4'hF) begin
        errors++;
        $display("FAIL reset_data dut%0d: got addr=%h wd=%h rsp=%h be=%h want 0/0/0/f",
                 i, m_addr[i], m_wdata[i], rsp_data[i], m_be[i]);
      end
    end
  endtask

  task automatic test_read_zero_wait();
    do_txn(1'b1, 1'b0, 32'd5, 16'h0, 0, 32'h0000_8001, 1'b0, 1'b0);
    model_txn(1'b1, 1'b0, 0, 32'h0000_8001, 1'b0);
    checks++;
    if (obs_cycles !== 1 || !obs_rd || obs_wr) begin
      errors++;
      $display("FAIL rd0_bus: got cycles=%0d rd=%0b wr=%0b want 1/1/0", obs_cycles, obs_rd, obs_wr);
    end
    checks++;
    if (obs_addr[0] !== 32'h14 || obs_addr[1] !== 32'h4) begin
      errors++;
      $display("FAIL rd0_addr: got %h/%h want 00000014/00000004", obs_addr[0], obs_addr[1]);
    end
    checks++;
    if (obs_rsp_valid !== 1'b1 || obs_rsp_data[0] !== 16'h8001 || obs_ready_end !== 1'b1 || obs_ready_busy) begin
      errors++;
      $display("FAIL rd0_rsp: got vld=%b data=%h ready_end=%b ready_busy=%0b want 1/8001/1/0",
               obs_rsp_valid, obs_rsp_data[0], obs_ready_end, obs_ready_busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_data[0] !== 16'h8001) begin
      errors++;
      $display("FAIL rd0_pulse: got vld=%b data=%h want 0/8001", rsp_valid[0], rsp_data[0]);
    end
  endtask

  task automatic test_write_wait();
    do_txn(1'b0, 1'b1, 32'd3, 16'hFFFE, 3, 32'h0, 1'b0, 1'b0);
    model_txn(1'b0, 1'b1, 3, 32'h0, 1'b0);
    checks++;
    if (obs_cycles !== 4 || obs_rd || !obs_wr || obs_unstable) begin
      errors++;
      $display("FAIL wr3_bus: got cycles=%0d rd=%0b wr=%0b unstable=%0b want 4/0/1/0",
               obs_cycles, obs_rd, obs_wr, obs_unstable);
    end
    checks++;
    if (obs_addr[0] !== 32'h0C || obs_wd !== 32'hFFFF_FFFE || obs_be !== 4'hF) begin
      errors++;
      $display("FAIL wr3_data: got addr=%h wd=%h be=%h want 0000000c/fffffffe/f", obs_addr[0], obs_wd, obs_be);
    end
    checks++;
    if (obs_rsp_valid !== 1'b0 || obs_busy_rsp || obs_rsp_data[0] !== model_rsp) begin
      errors++;
      $display("FAIL wr3_norsp: got vld=%b busy_vld=%0b data=%h want 0/0/%h",
               obs_rsp_valid, obs_busy_rsp, obs_rsp_data[0], model_rsp);
    end
  endtask

  task automatic test_collision();
    do_txn(1'b1, 1'b1, 32'd7, 16'h1234, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    model_txn(1'b1, 1'b1, 1, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (obs_rd || !obs_wr || obs_cycles !== 2 || obs_wd !== 32'h0000_1234 || obs_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL coll_bus: got rd=%0b wr=%0b cycles=%0d wd=%h vld=%b want 0/1/2/00001234/0",
               obs_rd, obs_wr, obs_cycles, obs_wd, obs_rsp_valid);
    end
    checks++;
    if (obs_err[0] !== 1'b1 || obs_err[1] !== 1'b1) begin
      errors++;
      $display("FAIL coll_err: got %b/%b want 1", obs_err[0], obs_err[1]);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 0; model_rd = 0; model_wr = 0; model_stall = 0;
    checks++;
    if (err[0] !== 1'b0 || err[1] !== 1'b0) begin
      errors++;
      $display("FAIL coll_clr: got %b/%b want 0", err[0], err[1]);
    end
    // Collision and clear on the same edge: set must win.
    do_txn(1'b1, 1'b1, 32'd9, 16'h8000, 0, 32'h0, 1'b1, 1'b0);
    model_txn(1'b1, 1'b1, 0, 32'h0, 1'b1);
    checks++;
    if (obs_err[0] !== model_err || obs_wd !== 32'hFFFF_8000) begin
      errors++;
      $display("FAIL coll_setwins: got err=%b wd=%h want %b/ffff8000", obs_err[0], obs_wd, model_err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 0; model_rd = 0; model_wr = 0; model_stall = 0;
  endtask

  task automatic test_timeout();
    do_txn(1'b1, 1'b0, 32'd2, 16'h0, 1000, 32'h5555_5555, 1'b0, 1'b0);
    model_txn(1'b1, 1'b0, 1000, 32'h5555_5555, 1'b0);
    checks++;
    if (obs_cycles !== TMO || obs_rsp_valid !== 1'b1 || obs_rsp_data[0] !== 16'h0 ||
        obs_err[0] !== 1'b1 || obs_ready_end !== 1'b1) begin
      errors++;
      $display("FAIL tmo_rd: got cycles=%0d vld=%b data=%h err=%b ready=%b want %0d/1/0000/1/1",
               obs_cycles, obs_rsp_valid, obs_rsp_data[0], obs_err[0], obs_ready_end, TMO);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 0; model_rd = 0; model_wr = 0; model_stall = 0;
    // One stall short of the limit must complete normally.
    do_txn(1'b1, 1'b0, 32'd4, 16'h0, TMO - 1, 32'h0000_7A5C, 1'b0, 1'b0);
    model_txn(1'b1, 1'b0, TMO - 1, 32'h0000_7A5C, 1'b0);
    checks++;
    if (obs_cycles !== TMO || obs_rsp_data[0] !== 16'h7A5C || obs_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL tmo_edge: got cycles=%0d data=%h err=%b want %0d/7a5c/0",
               obs_cycles, obs_rsp_data[0], obs_err[0], TMO);
    end
    do_txn(1'b0, 1'b1, 32'd6, 16'h00AA, TMO, 32'h0, 1'b0, 1'b0);
    model_txn(1'b0, 1'b1, TMO, 32'h0, 1'b0);
    checks++;
    if (obs_cycles !== TMO || obs_rsp_valid !== 1'b0 || obs_err[0] !== 1'b1 || obs_rsp_data[0] !== 16'h7A5C) begin
      errors++;
      $display("FAIL tmo_wr: got cycles=%0d vld=%b err=%b data=%h want %0d/0/1/7a5c",
               obs_cycles, obs_rsp_valid, obs_err[0], obs_rsp_data[0], TMO);
    end
  endtask

  task automatic test_reset_mid_read();
    bit saw_vld;
    re = 1'b1; addr = 32'd11; waitreq = 1'b1;
    @(negedge clk);
    re = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_read[0] !== 1'b0 || rdy[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || err[0] !== 1'b0 ||
        m_read[1] !== 1'b0 || rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got rd=%b rdy=%b vld=%b err=%b want 0/1/0/0",
               m_read[0], rdy[0], rsp_valid[0], err[0]);
    end
    rst = 1'b0; waitreq = 1'b0;
    model_err = 0; model_rsp = 0; model_rd = 0; model_wr = 0; model_stall = 0;
    saw_vld = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid[0] | rsp_valid[1] | m_read[0]) saw_vld = 1;
    end
    checks++;
    if (saw_vld || rsp_data[0] !== 16'h0) begin
      errors++;
      $display("FAIL rst_quiet: got late_activity=%0b data=%h want 0/0000", saw_vld, rsp_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    logic [31:0] rd;
    do_txn(1'b1, 1'b0, 32'd8, 16'h0, 0, 32'h0000_0042, 1'b0, 1'b0);
    model_txn(1'b1, 1'b0, 0, 32'h0000_0042, 1'b0);
    checks++;
    if (obs_addr[0] !== 32'h20 || obs_addr[1] !== 32'h10) begin
      errors++;
      $display("FAIL addr_wrap: got %h/%h want 00000020/00000010", obs_addr[0], obs_addr[1]);
    end
    start = cyc;
    for (int n = 0; n < 10; n++) begin
      rd = $urandom;
      do_txn(1'b1, 1'b0, $urandom, 16'h0, 0, rd, (n == 0), 1'b0);
      model_txn(1'b1, 1'b0, 0, rd, (n == 0));
      checks++;
      if (obs_rsp_valid !== 1'b1 || obs_rsp_data[0] !== rd[15:0] || obs_rsp_data[1] !== rd[15:0]) begin
        errors++;
        $display("FAIL b2b_rd%0d: got vld=%b data=%h/%h want 1/%h",
                 n, obs_rsp_valid, obs_rsp_data[0], obs_rsp_data[1], rd[15:0]);
      end
    end
    checks++;
    if (cyc - start !== 20) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d want 20", cyc - start);
    end
`ifdef MEM_BRIDGE_PERF_CNT_EN
    checks++;
    if (rd_cnt[0] !== 32'd10 || wr_cnt[0] !== 32'd0) begin
      errors++;
      $display("FAIL b2b_rdcount: got rd=%0d wr=%0d want 10/0", rd_cnt[0], wr_cnt[0]);
    end
`endif
  endtask

  task automatic test_random_mix();
    int          sel, waits;
    logic        r, w, clr;
    logic [31:0] a, rd;
    logic [15:0] d;
    for (int n = 0; n < 40; n++) begin
      sel   = $urandom_range(0, 5);
      r     = (sel <= 2) || (sel == 5);
      w     = (sel >= 3);
      waits = $urandom_range(0, 10);
      clr   = ($urandom_range(0, 7) == 0);
      a     = $urandom;
      d     = 16'($urandom);
      rd    = $urandom;
      do_txn(r, w, a, d, waits, rd, clr, 1'b1);
      model_txn(r, w, waits, rd, clr);
      checks++;
      if (obs_cycles !== exp_cycles(waits) || obs_rd !== !w || obs_wr !== w) begin
        errors++;
        $display("FAIL mix%0d_bus: got cycles=%0d rd=%0b wr=%0b want %0d/%0b/%0b",
                 n, obs_cycles, obs_rd, obs_wr, exp_cycles(waits), !w, w);
      end
      checks++;
      if (obs_addr[0] !== exp_addr(0, a) || obs_addr[1] !== exp_addr(1, a) ||
          (w && obs_wd !== exp_sext(d))) begin
        errors++;
        $display("FAIL mix%0d_addr: got %h/%h wd=%h want %h/%h wd=%h", n, obs_addr[0], obs_addr[1],
                 obs_wd, exp_addr(0, a), exp_addr(1, a), exp_sext(d));
      end
      checks++;
      if (obs_unstable || obs_busy_rsp || obs_ready_busy || obs_ready_end !== 1'b1) begin
        errors++;
        $display("FAIL mix%0d_hs: got unstable=%0b busy_vld=%0b busy_rdy=%0b ready_end=%b want 0/0/0/1",
                 n, obs_unstable, obs_busy_rsp, obs_ready_busy, obs_ready_end);
      end
      checks++;
      if (obs_rsp_valid !== !w || obs_rsp_data[0] !== model_rsp || obs_rsp_data[1] !== model_rsp) begin
        errors++;
        $display("FAIL mix%0d_rsp: got vld=%b data=%h/%h want %b/%h",
                 n, obs_rsp_valid, obs_rsp_data[0], obs_rsp_data[1], !w, model_rsp);
      end
      checks++;
      if (obs_err[0] !== model_err || obs_err[1] !== model_err) begin
        errors++;
        $display("FAIL mix%0d_err: got %b/%b want %b", n, obs_err[0], obs_err[1], model_err);
      end
`ifdef MEM_BRIDGE_PERF_CNT_EN
      checks++;
      if (rd_cnt[0] !== 32'(model_rd) || wr_cnt[0] !== 32'(model_wr) || stall_cnt[0] !== 32'(model_stall)) begin
        errors++;
        $display("FAIL mix%0d_perf: got rd=%0d wr=%0d stall=%0d want %0d/%0d/%0d",
                 n, rd_cnt[0], wr_cnt[0], stall_cnt[0], model_rd, model_wr, model_stall);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_collision();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
